// File: rtl/cpu_pkg.sv
// Shared CPU types: boot loader state encoding and stream constants.
// IMEM_LOADER_CHECKSUM_EN adds the trailing checksum state.
package cpu_pkg;

   localparam int IMEM_HDR_BYTES = 4;

   typedef enum logic [2:0] {
      LD_HDR  = 3'd0,
      LD_DATA = 3'd1,
`ifdef IMEM_LOADER_CHECKSUM_EN
      LD_CSUM = 3'd2,
`endif
      LD_DONE = 3'd3,
      LD_ERR  = 3'd4
   } loader_state_t;

endpackage

// File: rtl/imem_loader_word_assembler.sv
// Little-endian byte-to-word packer shared by header and payload phases.
// The word is presented combinationally on the edge taking its last byte.
module word_assembler
   import cpu_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        en,
   input  logic [7:0]  din,
   output logic [31:0] word,
   output logic        word_done
);

   logic [1:0]  cnt;
   logic [23:0] sh;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= 2'd0;
         sh  <= 24'd0;
      end else if (en) begin
         cnt <= cnt + 2'd1;
         sh  <= {din, sh[23:8]};
      end
   end

   assign word      = {din, sh};
   assign word_done = en && (cnt == 2'(IMEM_HDR_BYTES - 1));

endmodule

// File: rtl/imem_loader.sv
// Boot-time instruction memory writer; holds the core in reset until loaded.
// Define IMEM_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte.
module imem_loader
   import cpu_pkg::*;
#(
   parameter int DEPTH = 256
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        s_valid,
   output logic        s_ready,
   input  logic [7:0]  s_data,
   output logic        imem_we,
   output logic [31:0] imem_waddr,
   output logic [31:0] imem_wdata,
   output logic        cpu_rst_n,
   output logic        done,
   output logic        error
);

   localparam int AW  = $clog2(DEPTH);
   localparam int PAD = 32 - AW - 3;

`ifdef IMEM_LOADER_CHECKSUM_EN
   localparam loader_state_t LD_FIN = LD_CSUM;
`else
   localparam loader_state_t LD_FIN = LD_DONE;
`endif

   loader_state_t state, state_nxt;

   logic [AW:0]  word_idx;
   logic [AW:0]  n_words;
   logic         accept;
   logic         asm_en;
   logic [31:0]  word;
   logic         word_done;
   logic         last_word;
   logic         data_wr;
   logic         ready_nxt;
   logic         busy_nxt;

   assign accept    = s_valid && s_ready;
   assign asm_en    = accept && (state == LD_HDR || state == LD_DATA);
   assign last_word = (word_idx == n_words - {{AW{1'b0}}, 1'b1});
   assign data_wr   = (state == LD_DATA) && word_done;

   word_assembler u_asm (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (asm_en),
      .din       (s_data),
      .word      (word),
      .word_done (word_done)
   );

`ifdef IMEM_LOADER_CHECKSUM_EN
   logic [7:0] csum;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         csum <= 8'd0;
      end else if (accept && state == LD_DATA) begin
         csum <= csum ^ s_data;
      end
   end
`else
   // Last write is held one cycle so done trails the final imem_we pulse.
   logic wr_last;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_last <= 1'b0;
      end else if (data_wr && last_word) begin
         wr_last <= 1'b1;
      end
   end
`endif

   always_comb begin
      state_nxt = state;
      unique case (state)
         LD_HDR: begin
            if (word_done) begin
               if (word > 32'(DEPTH)) begin
                  state_nxt = LD_ERR;
               end else if (word == 32'd0) begin
                  state_nxt = LD_FIN;
               end else begin
                  state_nxt = LD_DATA;
               end
            end
         end
         LD_DATA: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            if (word_done && last_word) begin
               state_nxt = LD_CSUM;
            end
`else
            if (wr_last) begin
               state_nxt = LD_DONE;
            end
`endif
         end
`ifdef IMEM_LOADER_CHECKSUM_EN
         LD_CSUM: begin
            if (accept) begin
               state_nxt = (s_data == csum) ? LD_DONE : LD_ERR;
            end
         end
`endif
         default: state_nxt = state;
      endcase
   end

   always_comb begin
      busy_nxt = (state_nxt == LD_HDR) || (state_nxt == LD_DATA);
`ifdef IMEM_LOADER_CHECKSUM_EN
      busy_nxt = busy_nxt || (state_nxt == LD_CSUM);
      ready_nxt = busy_nxt;
`else
      ready_nxt = busy_nxt && !(data_wr && last_word) && !wr_last;
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= LD_HDR;
         word_idx <= '0;
         n_words  <= '0;
      end else begin
         state <= state_nxt;
         if (state == LD_HDR && word_done) begin
            n_words <= word[AW:0];
         end
         if (data_wr) begin
            word_idx <= word_idx + {{AW{1'b0}}, 1'b1};
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s_ready    <= 1'b0;
         imem_we    <= 1'b0;
         imem_waddr <= 32'd0;
         imem_wdata <= 32'd0;
         cpu_rst_n  <= 1'b0;
         done       <= 1'b0;
         error      <= 1'b0;
      end else begin
         s_ready   <= ready_nxt;
         imem_we   <= data_wr;
         cpu_rst_n <= (state_nxt == LD_DONE);
         done      <= (state_nxt == LD_DONE);
         error     <= (state_nxt == LD_ERR);
         if (data_wr) begin
            imem_waddr <= {{PAD{1'b0}}, word_idx, 2'b00};
            imem_wdata <= word;
         end
      end
   end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: image table plus reset-mid-load sequence.
// Honours IMEM_LOADER_CHECKSUM_EN for the checksum byte.
module tb_imem_loader;

   localparam int DEPTH = 256;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        s_valid = 1'b0;
   logic [7:0]  s_data = 8'd0;
   logic        s_ready;
   logic        imem_we;
   logic [31:0] imem_waddr;
   logic [31:0] imem_wdata;
   logic        cpu_rst_n;
   logic        done;
   logic        error;

   imem_loader #(.DEPTH(DEPTH)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .s_valid    (s_valid),
      .s_ready    (s_ready),
      .s_data     (s_data),
      .imem_we    (imem_we),
      .imem_waddr (imem_waddr),
      .imem_wdata (imem_wdata),
      .cpu_rst_n  (cpu_rst_n),
      .done       (done),
      .error      (error)
   );

   always #5 clk = ~clk;

   // cs: -1 no checksum byte, -2 computed checksum, else explicit byte
   typedef struct {
      logic [31:0] hdr;
      int          nsend;
      logic [31:0] w0;
      logic [31:0] w1;
      bit          tog;
      int          cs;
      int          nw;
      bit          exp_done;
      bit          exp_err;
   } vec_t;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   int done_cyc = 0;
   logic done_q = 1'b0;
   logic [31:0] wa_q[$];
   logic [31:0] wd_q[$];
   int          wc_q[$];
   vec_t        tbl[$];

   always @(negedge clk) begin
      cyc = cyc + 1;
      if (imem_we) begin
         wa_q.push_back(imem_waddr);
         wd_q.push_back(imem_wdata);
         wc_q.push_back(cyc);
      end
      if (done && !done_q) done_cyc = cyc;
      done_q = done;
   end

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic [31:0] hdr, input int nsend,
                               input logic [31:0] w0, input logic [31:0] w1,
                               input bit tog, input int cs, input int nw,
                               input bit d, input bit e);
      vec_t v;
      v.hdr = hdr; v.nsend = nsend; v.w0 = w0; v.w1 = w1; v.tog = tog;
      v.cs = cs; v.nw = nw; v.exp_done = d; v.exp_err = e;
      return v;
   endfunction

   function automatic logic [31:0] word_of(input vec_t v, input int i);
      if (i == 0) return v.w0;
      if (i == 1) return v.w1;
      return 32'hA500_0000 | 32'(i);
   endfunction

   task automatic send_byte(input logic [7:0] b, input bit tog);
      int t;
      t = 0;
      while (!s_ready && t < 10) begin
         s_valid = 1'b0;
         @(negedge clk);
         t++;
      end
      if (!s_ready) begin
         chk("ready_wait", 64'(s_ready), 64'(1'b1));
         return;
      end
      s_valid = 1'b1;
      s_data  = b;
      @(negedge clk);
      if (tog) begin
         s_valid = 1'b0;
         @(negedge clk);
      end
   endtask

   task automatic do_reset();
      s_valid = 1'b0;
      rst_n = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("reset_ctl", 64'({s_ready, imem_we, cpu_rst_n, done, error}), 64'(0));
      chk("reset_bus", 64'({imem_waddr, imem_wdata}), 64'(0));
      rst_n = 1'b1;
      @(negedge clk);
      chk("ready_after_reset", 64'(s_ready), 64'(1'b1));
   endtask

   task automatic run_vec(input vec_t v, input int idx);
      int          base;
      int          got;
      logic [7:0]  x;
      logic [31:0] w;
      string       tag;
      tag = $sformatf("v%0d", idx);
      do_reset();
      base = wa_q.size();
      x = 8'd0;
      for (int b = 0; b < 4; b++) send_byte(8'(v.hdr >> (8 * b)), v.tog);
      for (int i = 0; i < v.nsend; i++) begin
         w = word_of(v, i);
         for (int b = 0; b < 4; b++) begin
            send_byte(8'(w >> (8 * b)), v.tog);
            x = x ^ 8'(w >> (8 * b));
         end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      if (v.cs == -2) send_byte(x, v.tog);
      else if (v.cs >= 0) send_byte(8'(v.cs), v.tog);
`endif
      s_valid = 1'b0;
      chk({tag, "_ready_low"}, 64'(s_ready), 64'(1'b0));
      repeat (3) @(negedge clk);
      chk({tag, "_done"}, 64'(done), 64'(v.exp_done));
      chk({tag, "_error"}, 64'(error), 64'(v.exp_err));
      chk({tag, "_cpu_rst_n"}, 64'(cpu_rst_n), 64'(v.exp_done));
      chk({tag, "_ready_end"}, 64'(s_ready), 64'(1'b0));
      got = wa_q.size() - base;
      chk({tag, "_nwrites"}, 64'(got), 64'(v.nw));
      for (int j = 0; j < got && j < v.nw; j++) begin
         chk($sformatf("%s_addr%0d", tag, j), 64'(wa_q[base + j]), 64'(j * 4));
         chk($sformatf("%s_data%0d", tag, j), 64'(wd_q[base + j]),
             64'(word_of(v, j)));
      end
      if (v.exp_done && got > 0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
         chk({tag, "_done_after_we"},
             64'(done_cyc > wc_q[base + got - 1]), 64'(1'b1));
`else
         chk({tag, "_done_timing"}, 64'(done_cyc),
             64'(wc_q[base + got - 1] + 1));
`endif
      end
   endtask

   initial begin
      int base;
      int pre;
      logic [7:0] bytes[$];

      tbl.push_back(mk(2, 2, 32'h0050_0093, 32'h00A0_0113, 0, -2, 2, 1, 0));
      tbl.push_back(mk(2, 2, 32'h0050_0093, 32'h00A0_0113, 1, -2, 2, 1, 0));
      tbl.push_back(mk(257, 0, 0, 0, 0, -1, 0, 0, 1));
      tbl.push_back(mk(0, 0, 0, 0, 0, -2, 0, 1, 0));
      tbl.push_back(mk(3, 3, 32'hFFFF_FFFF, 32'h8000_0001, 0, -2, 3, 1, 0));
      tbl.push_back(mk(256, 256, 32'h1357_9BDF, 32'h0246_8ACE, 0, -2, 256, 1, 0));
`ifdef IMEM_LOADER_CHECKSUM_EN
      tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 1));
      tbl.push_back(mk(1, 1, 32'h1234_5678, 0, 0, 8'h08, 1, 1, 0));
      tbl.push_back(mk(1, 1, 32'h1234_5678, 0, 0, 8'h09, 1, 0, 1));
`endif

      for (int k = 0; k < tbl.size(); k++) run_vec(tbl[k], k);

      // Reset after 6 payload bytes of an N=3 image, then a fresh N=1 image
      do_reset();
      pre = wa_q.size();
      bytes = '{8'h03, 8'h00, 8'h00, 8'h00,
                8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
      foreach (bytes[i]) send_byte(bytes[i], 1'b0);
      s_valid = 1'b0;
      @(negedge clk);
      chk("mid_partial_writes", 64'(wa_q.size() - pre), 64'(1));
      rst_n = 1'b0;
      #1;
      chk("mid_reset_ctl", 64'({s_ready, imem_we, cpu_rst_n, done, error}), 64'(0));
      chk("mid_reset_bus", 64'({imem_waddr, imem_wdata}), 64'(0));
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      base = wa_q.size();
      bytes = '{8'h01, 8'h00, 8'h00, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
      foreach (bytes[i]) send_byte(bytes[i], 1'b0);
`ifdef IMEM_LOADER_CHECKSUM_EN
      send_byte(8'h22, 1'b0);
`endif
      s_valid = 1'b0;
      repeat (3) @(negedge clk);
      chk("mid_nwrites", 64'(wa_q.size() - base), 64'(1));
      if (wa_q.size() > base) begin
         chk("mid_addr", 64'(wa_q[base]), 64'(0));
         chk("mid_data", 64'(wd_q[base]), 64'(32'hDEAD_BEEF));
      end
      chk("mid_done", 64'(done), 64'(1'b1));
      chk("mid_cpu_rst_n", 64'(cpu_rst_n), 64'(1'b1));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
